// File: rtl/bit_scan_encoder.sv
// Streams the bit positions of each set bit of an accepted vector, one beat per handshake.
// Optional BIT_SCAN_POPCOUNT_EN adds out_count, the population count of the accepted vector.
module bit_scan_encoder #(
   parameter int unsigned  WIDTH     = 8,
   parameter int unsigned  MSB_FIRST = 0,
   localparam int unsigned IDX_W     = $clog2(WIDTH),
   localparam int unsigned CNT_W     = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] data_in,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_index,
   output logic             out_none,
   output logic             out_last
`ifdef BIT_SCAN_POPCOUNT_EN
   ,
   output logic [CNT_W-1:0] out_count
`endif
);

   typedef enum logic [0:0] {StIdle, StScan} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pend_q, pend_d;

   logic [IDX_W-1:0] sel_idx;
   logic [WIDTH-1:0] sel_mask;
   logic             multi_bit;
   logic             scan_active;

   // Priority select over pend; the last hit in loop order wins, so the
   // loop direction is the reverse of the scan order.
   always_comb begin
      sel_idx  = '0;
      sel_mask = '0;
      if (MSB_FIRST == 0) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
               sel_idx     = IDX_W'(i);
               sel_mask    = '0;
               sel_mask[i] = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (pend_q[i]) begin
               sel_idx     = IDX_W'(i);
               sel_mask    = '0;
               sel_mask[i] = 1'b1;
            end
         end
      end
   end

   assign multi_bit   = |(pend_q & (pend_q - WIDTH'(1)));
   assign scan_active = (state_q == StScan);

   // All outputs derive from registered state only.
   always_comb begin
      in_ready  = ~scan_active;
      out_valid = scan_active;
      out_index = scan_active ? sel_idx : '0;
      out_none  = scan_active & ~(|pend_q);
      out_last  = scan_active & ~multi_bit;
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               pend_d  = data_in;
               state_d = StScan;
            end
         end
         StScan: begin
            if (out_ready) begin
               pend_d = pend_q & ~sel_mask;
               if (!multi_bit) begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
            pend_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

`ifdef BIT_SCAN_POPCOUNT_EN
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] ones;

   always_comb begin
      ones = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ones = ones + CNT_W'(data_in[i]);
      end
   end

   always_comb begin
      count_d = count_q;
      if (!scan_active && in_valid) begin
         count_d = ones;
      end else if (scan_active && out_ready && !multi_bit) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign out_count = scan_active ? count_q : '0;
`endif

endmodule
